// File: rtl/inst_sched_pkg.sv
// Shared types, default constants and the pointer-advance helper for the
// round-robin grant scheduler.
package inst_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

  localparam int NUM_REQ = 5;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;

  // Wraps at n-1 back to 0, never at the power of two above it.
  function automatic int next_ptr(input int id, input int n = NUM_REQ);
    return (id >= n - 1) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/inst_rr_scheduler_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo NUM_REQ, via a double-width masked priority encode.
module rr_pick #(
  parameter int NUM_REQ = 5,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [ID_W-1:0]    pick_id
);

  logic [2*NUM_REQ-1:0] dbl_req;
  logic [2*NUM_REQ-1:0] masked;
  logic                 found;
  int                   idx;

  // Lower copy is masked below ptr; the upper copy supplies the wrapped tail.
  always_comb begin
    dbl_req = {req, req};
    masked  = '0;
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      masked[i] = dbl_req[i] && ((i >= NUM_REQ) || (i >= int'(ptr)));
    end
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        idx   = (i >= NUM_REQ) ? (i - NUM_REQ) : i;
      end
    end
    if (found) begin
      pick[idx] = 1'b1;
      pick_id   = ID_W'(idx);
    end
  end

endmodule

// File: rtl/inst_rr_scheduler.sv
// Round-robin scheduler sharing one resource among NUM_REQ requesters.
// Optional forced release after TIMEOUT busy cycles: INST_RR_SCHED_TIMEOUT_EN.
module inst_rr_scheduler #(
  parameter int NUM_REQ = inst_sched_pkg::NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = inst_sched_pkg::TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout_err
);

  import inst_sched_pkg::*;

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1 || TIMEOUT > 255 ||
      ID_W != $clog2(NUM_REQ)) begin : g_bad_params
    $error("inst_rr_scheduler: parameter out of range");
  end

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] pick;
  logic [ID_W-1:0]    pick_id;
  logic               release_grant;

`ifdef INST_RR_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .pick    (pick),
    .pick_id (pick_id)
  );

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gnt_id_d      = gnt_id_q;
    ptr_d         = ptr_q;
    release_grant = 1'b0;
`ifdef INST_RR_SCHED_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = BUSY;
          gnt_d    = pick;
          gnt_id_d = pick_id;
`ifdef INST_RR_SCHED_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      BUSY: begin
        // done has priority over expiry, so a coinciding pair never pulses.
        if (done) begin
          release_grant = 1'b1;
`ifdef INST_RR_SCHED_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          release_grant = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // gnt_id is left alone on release; consumers qualify it with busy.
    if (release_grant) begin
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = ID_W'(next_ptr(int'(gnt_id_q), NUM_REQ));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      gnt_id_q      <= '0;
      ptr_q         <= '0;
`ifdef INST_RR_SCHED_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      gnt_id_q      <= gnt_id_d;
      ptr_q         <= ptr_d;
`ifdef INST_RR_SCHED_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = (state_q == BUSY);

`ifdef INST_RR_SCHED_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_rr_scheduler.sv
// Bench for inst_rr_scheduler: directed test-plan steps followed by random
// traffic, all compared against a behavioural round-robin model.
module tb_inst_rr_scheduler;

  localparam int N       = 5;
  localparam int IDW     = 3;
  localparam int TIMEOUT = 15;
`ifdef INST_RR_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout_err;

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Reference model: who holds the grant, where the scan starts next,
  // and how long the current grant has lasted.
  bit m_busy;
  int m_id;
  int m_ptr;
  int m_age;
  bit m_terr;

  inst_rr_scheduler #(
    .NUM_REQ (N),
    .ID_W    (IDW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      n_miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the spec's rules directly.
  task automatic modelStep(input logic [N-1:0] r, input logic d, input logic rs);
    if (rs) begin
      m_busy = 0; m_id = 0; m_ptr = 0; m_age = 0; m_terr = 0;
    end else begin
      m_terr = 0;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          if (!m_busy && r[(m_ptr + i) % N]) begin
            m_busy = 1;
            m_id   = (m_ptr + i) % N;
            m_age  = 1;
          end
        end
      end else if (d) begin
        m_busy = 0;
        m_ptr  = (m_id + 1) % N;
      end else if (TO_EN && m_age == TIMEOUT) begin
        m_busy = 0;
        m_ptr  = (m_id + 1) % N;
        m_terr = 1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0] exp_gnt;
    exp_gnt = m_busy ? (N'(1) << m_id) : '0;
    checkValue("gnt",         32'(gnt),         32'(exp_gnt));
    checkValue("gnt_id",      32'(gnt_id),      32'(m_id));
    checkValue("busy",        32'(busy),        32'(m_busy));
    checkValue("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare at negedge.
  task automatic applyStimulus(input logic [N-1:0] r, input logic d, input logic rs);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clk);
    modelStep(r, d, rs);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [N-1:0] r;
    int exp_seq [6] = '{0, 1, 2, 3, 4, 0};

    req = '0; done = 1'b0; rst = 1'b1;
    m_busy = 0; m_id = 0; m_ptr = 0; m_age = 0; m_terr = 0;

    $display("[TB] step 1: reset and single grant");
    applyStimulus(5'b00000, 1'b0, 1'b1);
    applyStimulus(5'b00000, 1'b0, 1'b1);
    checkValue("reset_gnt",  32'(gnt),  32'h0);
    checkValue("reset_busy", 32'(busy), 32'h0);
    applyStimulus(5'b00001, 1'b0, 1'b0);
    checkValue("t1_gnt", 32'(gnt), 32'h01);
    applyStimulus(5'b00000, 1'b1, 1'b0);
    checkValue("t1_release_busy", 32'(busy), 32'h0);

    $display("[TB] step 2: rotation with all requesting");
    applyStimulus(5'b00000, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(5'b11111, 1'b0, 1'b0);
      checkValue("t2_seq_id", 32'(gnt_id), 32'(exp_seq[k]));
      applyStimulus(5'b11111, 1'b0, 1'b0);
      applyStimulus(5'b11111, 1'b1, 1'b0);
      checkValue("t2_idle_gap", 32'(busy), 32'h0);
    end

    $display("[TB] step 3: pointer wrap");
    applyStimulus(5'b10000, 1'b0, 1'b0);
    checkValue("t3_gnt4", 32'(gnt_id), 32'd4);
    applyStimulus(5'b10000, 1'b1, 1'b0);
    applyStimulus(5'b10001, 1'b0, 1'b0);
    checkValue("t3_wrap_id", 32'(gnt_id), 32'd0);
    applyStimulus(5'b00000, 1'b1, 1'b0);

    $display("[TB] step 4: grant lock");
    applyStimulus(5'b00100, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(5'b01000, 1'b0, 1'b0);
      checkValue("t4_locked", 32'(gnt), 32'h04);
    end
    applyStimulus(5'b01000, 1'b1, 1'b0);
    applyStimulus(5'b01000, 1'b0, 1'b0);
    checkValue("t4_next_gnt", 32'(gnt), 32'h08);
    applyStimulus(5'b00000, 1'b1, 1'b0);

    $display("[TB] step 5: held grant without done");
    applyStimulus(5'b00000, 1'b0, 1'b1);
    applyStimulus(5'b00100, 1'b0, 1'b0);
    if (TO_EN) begin
      for (int k = 1; k < TIMEOUT; k++) begin
        applyStimulus(5'b00100, 1'b0, 1'b0);
        checkValue("t5_held", 32'(busy), 32'h1);
      end
      applyStimulus(5'b00000, 1'b0, 1'b0);
      checkValue("t5_release", 32'(busy), 32'h0);
      checkValue("t5_pulse", 32'(timeout_err), 32'h1);
      applyStimulus(5'b11111, 1'b0, 1'b0);
      checkValue("t5_pulse_end", 32'(timeout_err), 32'h0);
      checkValue("t5_ptr", 32'(gnt_id), 32'd3);
    end else begin
      for (int k = 0; k < 100; k++) applyStimulus(5'b00100, 1'b0, 1'b0);
      checkValue("t5_still_held", 32'(gnt), 32'h04);
      checkValue("t5_no_err", 32'(timeout_err), 32'h0);
    end
    applyStimulus(5'b00000, 1'b1, 1'b0);

    $display("[TB] step 6: reset mid-grant");
    applyStimulus(5'b00000, 1'b0, 1'b1);
    applyStimulus(5'b00010, 1'b0, 1'b0);
    applyStimulus(5'b00010, 1'b0, 1'b0);
    applyStimulus(5'b00010, 1'b0, 1'b0);
    applyStimulus(5'b00010, 1'b0, 1'b1);
    checkValue("t6_gnt", 32'(gnt), 32'h0);
    checkValue("t6_id", 32'(gnt_id), 32'h0);
    applyStimulus(5'b00011, 1'b0, 1'b0);
    checkValue("t6_regrant", 32'(gnt_id), 32'd0);

    $display("[TB] random traffic");
    for (int k = 0; k < 600; k++) begin
      r = N'($urandom);
      applyStimulus(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
